ramb_arbiter: RTL and testbench



---
 rtl/ramb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ramb_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb_arbiter.sv
// Round-robin arbiter sharing upper-RAM port B between the DCB DMA engine (m0) and the disk loader (m1).
// One access at a time, registered outputs; optional contention counter behind RAMB_ARB_STATS_EN.
module ramb_arbiter #(
  parameter int AW     = 15,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic          m0_wr_i,
  input  logic          m0_rd_i,
  input  logic [7:0]    m0_dout_i,
  output logic [7:0]    m0_din_o,
  output logic          m0_wr_ack_o,
  output logic          m0_rd_ack_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic          m1_wr_i,
  input  logic          m1_rd_i,
  input  logic [7:0]    m1_dout_i,
  output logic [7:0]    m1_din_o,
  output logic          m1_wr_ack_o,
  output logic          m1_rd_ack_o,
  output logic [AW-1:0] ramb_addr_o,
  output logic          ramb_wr_o,
  output logic [7:0]    ramb_dout_o,
  input  logic [7:0]    ramb_din_i,
  output logic          busy_o
`ifdef RAMB_ARB_STATS_EN
  ,
  output logic [15:0]   contention_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic          op_wr_q, op_wr_d;
  logic [1:0]    lat_q, lat_d;
  logic [AW-1:0] ramb_addr_q, ramb_addr_d;
  logic [7:0]    ramb_dout_q, ramb_dout_d;
  logic          ramb_wr_q, ramb_wr_d;
  logic [7:0]    m0_din_q, m0_din_d, m1_din_q, m1_din_d;
  logic          m0_wr_ack_q, m0_wr_ack_d, m0_rd_ack_q, m0_rd_ack_d;
  logic          m1_wr_ack_q, m1_wr_ack_d, m1_rd_ack_q, m1_rd_ack_d;
  logic          busy_q, busy_d;
  logic          m0_req, m1_req, pick;
`ifdef RAMB_ARB_STATS_EN
  logic [15:0]   cont_q, cont_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_wr_d      = op_wr_q;
    lat_d        = lat_q;
    ramb_addr_d  = ramb_addr_q;
    ramb_dout_d  = ramb_dout_q;
    ramb_wr_d    = 1'b0;
    m0_din_d     = m0_din_q;
    m1_din_d     = m1_din_q;
    m0_wr_ack_d  = 1'b0;
    m0_rd_ack_d  = 1'b0;
    m1_wr_ack_d  = 1'b0;
    m1_rd_ack_d  = 1'b0;
`ifdef RAMB_ARB_STATS_EN
    cont_d       = cont_q;
`endif
    m0_req = m0_wr_i | m0_rd_i;
    m1_req = m1_wr_i | m1_rd_i;
    // Under contention the master that did not win last time goes next.
    pick   = (m0_req && m1_req) ? ~last_grant_q : m1_req;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d        = pick;
          last_grant_d = pick;
          op_wr_d      = pick ? m1_wr_i : m0_wr_i;
          ramb_addr_d  = pick ? m1_addr_i : m0_addr_i;
          ramb_dout_d  = pick ? m1_dout_i : m0_dout_i;
          ramb_wr_d    = pick ? m1_wr_i : m0_wr_i;
          state_d      = S_ISSUE;
`ifdef RAMB_ARB_STATS_EN
          if (m0_req && m1_req && cont_q != 16'hFFFF) cont_d = cont_q + 16'd1;
`endif
        end
      end
      S_ISSUE: begin
        if (op_wr_q) begin
          m0_wr_ack_d = ~gnt_q;
          m1_wr_ack_d = gnt_q;
          state_d     = S_ACK;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 2'd0) begin
          if (gnt_q) m1_din_d = ramb_din_i;
          else       m0_din_d = ramb_din_i;
          m0_rd_ack_d = ~gnt_q;
          m1_rd_ack_d = gnt_q;
          state_d     = S_ACK;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_wr_q      <= 1'b0;
      lat_q        <= 2'd0;
      ramb_addr_q  <= '0;
      ramb_dout_q  <= 8'd0;
      ramb_wr_q    <= 1'b0;
      m0_din_q     <= 8'd0;
      m1_din_q     <= 8'd0;
      m0_wr_ack_q  <= 1'b0;
      m0_rd_ack_q  <= 1'b0;
      m1_wr_ack_q  <= 1'b0;
      m1_rd_ack_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef RAMB_ARB_STATS_EN
      cont_q       <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_wr_q      <= op_wr_d;
      lat_q        <= lat_d;
      ramb_addr_q  <= ramb_addr_d;
      ramb_dout_q  <= ramb_dout_d;
      ramb_wr_q    <= ramb_wr_d;
      m0_din_q     <= m0_din_d;
      m1_din_q     <= m1_din_d;
      m0_wr_ack_q  <= m0_wr_ack_d;
      m0_rd_ack_q  <= m0_rd_ack_d;
      m1_wr_ack_q  <= m1_wr_ack_d;
      m1_rd_ack_q  <= m1_rd_ack_d;
      busy_q       <= busy_d;
`ifdef RAMB_ARB_STATS_EN
      cont_q       <= cont_d;
`endif
    end
  end

  assign ramb_addr_o = ramb_addr_q;
  assign ramb_dout_o = ramb_dout_q;
  assign ramb_wr_o   = ramb_wr_q;
  assign m0_din_o    = m0_din_q;
  assign m1_din_o    = m1_din_q;
  assign m0_wr_ack_o = m0_wr_ack_q;
  assign m0_rd_ack_o = m0_rd_ack_q;
  assign m1_wr_ack_o = m1_wr_ack_q;
  assign m1_rd_ack_o = m1_rd_ack_q;
  assign busy_o      = busy_q;
`ifdef RAMB_ARB_STATS_EN
  assign contention_cnt_o = cont_q;
`endif

endmodule

// File: tb/tb_ramb_arbiter.sv
// Bench for ramb_arbiter: RD_LAT=1 instance with an ack scoreboard, plus an RD_LAT=3 instance.
module tb_ramb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [14:0] m0_addr = '0, m1_addr = '0;
  logic        m0_wr = 0, m0_rd = 0, m1_wr = 0, m1_rd = 0;
  logic [7:0]  m0_dout = '0, m1_dout = '0;
  logic [7:0]  m0_din, m1_din;
  logic        m0_wr_ack, m0_rd_ack, m1_wr_ack, m1_rd_ack;
  logic [14:0] ramb_addr;
  logic        ramb_wr, busy;
  logic [7:0]  ramb_dout, ramb_din;
  logic [7:0]  mem [0:32767];

  logic [14:0] n_addr = '0;
  logic        n_wr = 0, n_rd = 0;
  logic [7:0]  n_dout = '0;
  logic [7:0]  n_din, n_m1_din;
  logic        n_wr_ack, n_rd_ack, n_m1_wr_ack, n_m1_rd_ack;
  logic [14:0] n_ramb_addr;
  logic        n_ramb_wr, n_busy;
  logic [7:0]  n_ramb_dout, n_ramb_din;
  logic [7:0]  mem3 [0:32767];
  logic [7:0]  pipe3 [0:2];
`ifdef RAMB_ARB_STATS_EN
  logic [15:0] cnt1, cnt3;
`endif

  typedef struct {
    bit         m;
    bit         rd;
    logic [7:0] d;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ramb_arbiter #(.AW(15), .RD_LAT(1)) u_dut (
`ifdef RAMB_ARB_STATS_EN
    .contention_cnt_o(cnt1),
`endif
    .clk_i(clk), .reset_n_i(rst_n),
    .m0_addr_i(m0_addr), .m0_wr_i(m0_wr), .m0_rd_i(m0_rd), .m0_dout_i(m0_dout),
    .m0_din_o(m0_din), .m0_wr_ack_o(m0_wr_ack), .m0_rd_ack_o(m0_rd_ack),
    .m1_addr_i(m1_addr), .m1_wr_i(m1_wr), .m1_rd_i(m1_rd), .m1_dout_i(m1_dout),
    .m1_din_o(m1_din), .m1_wr_ack_o(m1_wr_ack), .m1_rd_ack_o(m1_rd_ack),
    .ramb_addr_o(ramb_addr), .ramb_wr_o(ramb_wr), .ramb_dout_o(ramb_dout),
    .ramb_din_i(ramb_din), .busy_o(busy)
  );

  ramb_arbiter #(.AW(15), .RD_LAT(3)) u_dut3 (
`ifdef RAMB_ARB_STATS_EN
    .contention_cnt_o(cnt3),
`endif
    .clk_i(clk), .reset_n_i(rst_n),
    .m0_addr_i(n_addr), .m0_wr_i(n_wr), .m0_rd_i(n_rd), .m0_dout_i(n_dout),
    .m0_din_o(n_din), .m0_wr_ack_o(n_wr_ack), .m0_rd_ack_o(n_rd_ack),
    .m1_addr_i(15'h0), .m1_wr_i(1'b0), .m1_rd_i(1'b0), .m1_dout_i(8'h0),
    .m1_din_o(n_m1_din), .m1_wr_ack_o(n_m1_wr_ack), .m1_rd_ack_o(n_m1_rd_ack),
    .ramb_addr_o(n_ramb_addr), .ramb_wr_o(n_ramb_wr), .ramb_dout_o(n_ramb_dout),
    .ramb_din_i(n_ramb_din), .busy_o(n_busy)
  );

  // RAM models: registered address, q valid RD_LAT clocks later.
  always @(posedge clk) begin
    if (ramb_wr) mem[ramb_addr] <= ramb_dout;
    ramb_din <= mem[ramb_addr];
    if (n_ramb_wr) mem3[n_ramb_addr] <= n_ramb_dout;
    pipe3[0] <= mem3[n_ramb_addr];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign n_ramb_din = pipe3[2];

  // Scoreboard monitor for the RD_LAT=1 instance.
  always @(negedge clk) begin
    if (rst_n && (m0_wr_ack || m0_rd_ack || m1_wr_ack || m1_rd_ack)) begin
      exp_t e;
      logic gm, grd;
      logic [7:0] gd;
      gm  = m1_wr_ack | m1_rd_ack;
      grd = m0_rd_ack | m1_rd_ack;
      gd  = gm ? m1_din : m0_din;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: master=%0d rd=%0d cycle=%0d, none expected", gm, grd, cyc);
      end else begin
        e = sb.pop_front();
        if (gm !== e.m || grd !== e.rd || cyc != e.cyc) begin
          errors++;
          $display("FAIL ack_order: got master=%0d rd=%0d cycle=%0d, want master=%0d rd=%0d cycle=%0d",
                   gm, grd, cyc, e.m, e.rd, e.cyc);
        end
        if (e.rd) begin
          checks++;
          if (gd !== e.d) begin
            errors++;
            $display("FAIL rd_data: got %h want %h (master %0d)", gd, e.d, e.m);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    m0_wr = 0; m0_rd = 0; m1_wr = 0; m1_rd = 0; n_wr = 0; n_rd = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [44:0] v1, v3;
    do_reset();
    @(negedge clk);
    v1 = {m0_din, m0_wr_ack, m0_rd_ack, m1_din, m1_wr_ack, m1_rd_ack, ramb_addr, ramb_wr, ramb_dout, busy};
    v3 = {n_din, n_wr_ack, n_rd_ack, n_m1_din, n_m1_wr_ack, n_m1_rd_ack, n_ramb_addr, n_ramb_wr, n_ramb_dout, n_busy};
    checks++;
    if (v1 !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", v1); end
    checks++;
    if (v3 !== '0) begin errors++; $display("FAIL reset_outputs_lat3: got %h want 0", v3); end
`ifdef RAMB_ARB_STATS_EN
    checks++;
    if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_contention: got %0d want 0", cnt1); end
`endif
  endtask

  task automatic test_write();
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    m0_addr = 15'h1234; m0_dout = 8'hA5; m0_wr = 1;
    sb.push_back('{1'b0, 1'b0, 8'h00, c0 + 2});
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ramb_wr, ramb_addr, ramb_dout, busy} !== {1'b1, 15'h1234, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL issue_strobe: got wr=%0d addr=%h data=%h busy=%0d want 1/1234/a5/1", ramb_wr, ramb_addr, ramb_dout, busy);
    end
    @(negedge clk);
    checks++;
    if (ramb_wr !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: got %0d want 0", ramb_wr); end
    @(posedge clk); #1 m0_wr = 0;
    @(negedge clk);
    checks++;
    if ({ramb_addr, ramb_dout, ramb_wr, busy} !== {15'h1234, 8'hA5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: got addr=%h data=%h wr=%0d busy=%0d want 1234/a5/0/0", ramb_addr, ramb_dout, ramb_wr, busy);
    end
  endtask

  task automatic test_read();
    int c0, k;
    @(posedge clk); #1;
    c0 = cyc;
    m1_addr = 15'h1234; m1_rd = 1;
    sb.push_back('{1'b1, 1'b1, 8'hA5, c0 + 3});
    k = 0;
    do begin @(negedge clk); k++; end while (!m1_rd_ack && k < 20);
    if (!m1_rd_ack) begin errors++; checks++; $display("FAIL read_timeout: no m1_rd_ack in %0d cycles", k); end
    @(posedge clk); #1 m1_rd = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m0_din, m1_din} !== {8'h00, 8'hA5}) begin
      errors++;
      $display("FAIL din_hold: got m0=%h m1=%h want 00/a5", m0_din, m1_din);
    end
  endtask

  task automatic test_contention();
    int c0;
    do_reset();
    @(posedge clk); #1;
    c0 = cyc;
    m0_addr = 15'h0100; m0_dout = 8'h11; m1_addr = 15'h0200; m1_dout = 8'h22;
    m0_wr = 1; m1_wr = 1;
    sb.push_back('{1'b0, 1'b0, 8'h00, c0 + 2});
    sb.push_back('{1'b1, 1'b0, 8'h00, c0 + 5});
    sb.push_back('{1'b0, 1'b0, 8'h00, c0 + 8});
    sb.push_back('{1'b1, 1'b0, 8'h00, c0 + 11});
    repeat (12) @(negedge clk);
    @(posedge clk); #1 m0_wr = 0; m1_wr = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL contention_acks: %0d acks missing, want 0", sb.size()); sb.delete(); end
    checks++;
    if ({mem[15'h0100], mem[15'h0200]} !== {8'h11, 8'h22}) begin
      errors++;
      $display("FAIL contention_ram: got %h/%h want 11/22", mem[15'h0100], mem[15'h0200]);
    end
`ifdef RAMB_ARB_STATS_EN
    checks++;
    if (cnt1 !== 16'd4) begin errors++; $display("FAIL contention_cnt: got %0d want 4", cnt1); end
`endif
  endtask

  task automatic test_wr_then_rd();
    int c0, k;
    @(posedge clk); #1;
    c0 = cyc;
    m0_addr = 15'h0010; m0_dout = 8'h5C; m0_wr = 1; m0_rd = 1;
    sb.push_back('{1'b0, 1'b0, 8'h00, c0 + 2});
    sb.push_back('{1'b0, 1'b1, 8'h5C, c0 + 6});
    k = 0;
    do begin @(negedge clk); k++; end while (!m0_wr_ack && k < 20);
    if (!m0_wr_ack) begin errors++; checks++; $display("FAIL wrrd_wr_timeout: no wr_ack in %0d cycles", k); end
    @(posedge clk); #1 m0_wr = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!m0_rd_ack && k < 20);
    if (!m0_rd_ack) begin errors++; checks++; $display("FAIL wrrd_rd_timeout: no rd_ack in %0d cycles", k); end
    @(posedge clk); #1 m0_rd = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rd_lat3();
    int c0, k;
    logic [7:0] got;
    @(posedge clk); #1;
    c0 = cyc;
    n_addr = 15'h0777; n_dout = 8'h3E; n_wr = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!n_wr_ack && k < 20);
    checks++;
    if (!n_wr_ack || cyc != c0 + 2) begin
      errors++;
      $display("FAIL lat3_wr_ack: ack=%0d at cycle %0d want 1 at %0d", n_wr_ack, cyc, c0 + 2);
    end
    @(posedge clk); #1 n_wr = 0;
    @(posedge clk); #1;
    c0 = cyc;
    n_rd = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!n_rd_ack && k < 20);
    got = n_din;
    checks++;
    if (!n_rd_ack || cyc != c0 + 5) begin
      errors++;
      $display("FAIL lat3_rd_ack: ack=%0d at cycle %0d want 1 at %0d", n_rd_ack, cyc, c0 + 5);
    end
    checks++;
    if (got !== 8'h3E) begin errors++; $display("FAIL lat3_rd_data: got %h want 3e", got); end
    @(posedge clk); #1 n_rd = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c0, k;
    bit seen;
    logic [44:0] v1;
    @(posedge clk); #1;
    m0_addr = 15'h0010; m0_rd = 1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0d want 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    v1 = {m0_din, m0_wr_ack, m0_rd_ack, m1_din, m1_wr_ack, m1_rd_ack, ramb_addr, ramb_wr, ramb_dout, busy};
    checks++;
    if (v1 !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", v1); end
    m0_rd = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m0_rd_ack || m0_wr_ack || m1_rd_ack || m1_wr_ack) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_no_ack: got an ack after reset, want none"); end
    @(posedge clk); #1;
    c0 = cyc;
    m0_addr = 15'h0020; m0_dout = 8'h77; m1_addr = 15'h0021; m1_dout = 8'h88;
    m0_wr = 1; m1_wr = 1;
    sb.push_back('{1'b0, 1'b0, 8'h00, c0 + 2});
    sb.push_back('{1'b1, 1'b0, 8'h00, c0 + 5});
    fork
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!m0_wr_ack && k < 20);
        if (!m0_wr_ack) begin errors++; checks++; $display("FAIL mid_m0_timeout: no ack"); end
        @(posedge clk); #1 m0_wr = 0;
      end
      begin
        int j;
        j = 0;
        do begin @(negedge clk); j++; end while (!m1_wr_ack && j < 20);
        if (!m1_wr_ack) begin errors++; checks++; $display("FAIL mid_m1_timeout: no ack"); end
        @(posedge clk); #1 m1_wr = 0;
      end
    join
    repeat (3) @(negedge clk);
    checks++;
    if ({mem[15'h0020], mem[15'h0021]} !== {8'h77, 8'h88}) begin
      errors++;
      $display("FAIL mid_ram: got %h/%h want 77/88", mem[15'h0020], mem[15'h0021]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_wr_then_rd();
    test_rd_lat3();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expected acks never seen, want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
